// File: rtl/axi_read_master.sv
// AXI4 read master: issues one read burst per start_read request and pushes
// the returned beats into the DMA data FIFO, reporting completion and errors.
module axi_read_master #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 8,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                          AXI_aclk,
  input  logic                          AXI_areset,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] src_addr,
  input  logic [1:0]                    read_burst_type,
  input  logic [2:0]                    read_burst_size,
  input  logic [8:0]                    read_beats,
  input  logic                          start_read,
  output logic                          read_transaction_completed,
  output logic                          read_resp_error,
  output logic                          busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic                          fifo_wr_en,
  output logic [C_M_AXI_DATA_WIDTH-1:0] fifo_wr_data,
  input  logic                          fifo_full
);

  localparam int unsigned CNT_W = 9;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] RESP_OKAY   = 2'd0;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beats_q;
  logic             req_illegal;
  logic             last_beat;
  logic             beat_err;

  // Lengths the AXI4 protocol cannot express for this burst type.
  assign req_illegal = (read_beats == CNT_W'(0)) ||
                       (read_beats > CNT_W'(256)) ||
                       ((read_beats > CNT_W'(16)) &&
                        ((read_burst_type == BURST_FIXED) ||
                         (read_burst_type == BURST_WRAP)));

  // Burst length is owned by the request, not by RLAST.
  assign last_beat = (beat_cnt == (beats_q - CNT_W'(1)));
  assign beat_err  = (M_AXI_RRESP != RESP_OKAY) || (M_AXI_RLAST != last_beat);

  assign fifo_wr_data = M_AXI_RDATA;

  // State register.
  always_ff @(posedge AXI_aclk) begin
    if (AXI_areset) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state logic and combinational R-channel/FIFO handshake.
  always_comb begin
    state_next   = state;
    M_AXI_RREADY = 1'b0;
    fifo_wr_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start_read) state_next = req_illegal ? DONE : ADDR;
      end
      ADDR: begin
        if (M_AXI_ARVALID && M_AXI_ARREADY) state_next = DATA;
      end
      DATA: begin
        M_AXI_RREADY = !fifo_full;
        if (M_AXI_RVALID && !fifo_full) begin
          fifo_wr_en = 1'b1;
          if (last_beat) state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered AR channel, status outputs, beat counter and error flag.
  always_ff @(posedge AXI_aclk) begin
    if (AXI_areset) begin
      M_AXI_ARADDR               <= '0;
      M_AXI_ARLEN                <= '0;
      M_AXI_ARSIZE               <= '0;
      M_AXI_ARBURST              <= '0;
      M_AXI_ARVALID              <= 1'b0;
      read_transaction_completed <= 1'b0;
      read_resp_error            <= 1'b0;
      busy                       <= 1'b0;
      beat_cnt                   <= '0;
      beats_q                    <= '0;
    end else begin
      M_AXI_ARVALID              <= (state_next == ADDR);
      read_transaction_completed <= (state_next == DONE);
      busy                       <= (state_next != IDLE);

      if ((state == IDLE) && start_read) begin
        beats_q         <= read_beats;
        read_resp_error <= req_illegal;
        if (!req_illegal) begin
          M_AXI_ARADDR  <= src_addr;
          M_AXI_ARLEN   <= 8'(read_beats - CNT_W'(1));
          M_AXI_ARSIZE  <= read_burst_size;
          M_AXI_ARBURST <= read_burst_type;
        end
      end

      if ((state == ADDR) && M_AXI_ARVALID && M_AXI_ARREADY) beat_cnt <= '0;

      if (fifo_wr_en) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
        if (beat_err) read_resp_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_read_master.sv
// Scoreboard bench for axi_read_master: directed bursts push expected AR,
// FIFO data and completion status into queues; a monitor pops and compares.
module tb_axi_read_master;

  logic        clk = 1'b0;
  logic        AXI_areset;
  logic [7:0]  src_addr;
  logic [1:0]  read_burst_type;
  logic [2:0]  read_burst_size;
  logic [8:0]  read_beats;
  logic        start_read;
  logic        read_transaction_completed;
  logic        read_resp_error;
  logic        busy;
  logic [7:0]  M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        fifo_full;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [20:0] ar_q[$];
  logic [31:0] data_q[$];
  logic        cmp_q[$];

  logic [20:0] m_ar;
  logic [31:0] m_d;
  logic        m_e;

  axi_read_master #(.C_M_AXI_ADDR_WIDTH(8), .C_M_AXI_DATA_WIDTH(32)) dut (
    .AXI_aclk(clk), .AXI_areset(AXI_areset),
    .src_addr(src_addr), .read_burst_type(read_burst_type),
    .read_burst_size(read_burst_size), .read_beats(read_beats),
    .start_read(start_read),
    .read_transaction_completed(read_transaction_completed),
    .read_resp_error(read_resp_error), .busy(busy),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [7:0] addr, input int k);
    return 32'hD000_0000 | (32'(addr) << 16) | 32'(k);
  endfunction

  // Monitor: every DUT-presented event is matched against the scoreboard.
  always @(negedge clk) begin
    if (!AXI_areset) begin
      if (fifo_wr_en) begin
        check("push_expected", 64'(data_q.size() != 0), 64'd1);
        if (data_q.size() != 0) begin
          m_d = data_q.pop_front();
          check("fifo_data", 64'(fifo_wr_data), 64'(m_d));
        end
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        check("ar_expected", 64'(ar_q.size() != 0), 64'd1);
        if (ar_q.size() != 0) begin
          m_ar = ar_q.pop_front();
          check("ar_fields", 64'({M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST}),
                64'(m_ar));
        end
      end
      if (read_transaction_completed) begin
        check("completion_expected", 64'(cmp_q.size() != 0), 64'd1);
        if (cmp_q.size() != 0) begin
          m_e = cmp_q.pop_front();
          check("resp_error", 64'(read_resp_error), 64'(m_e));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    check(name, 64'({M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
                     M_AXI_RREADY, fifo_wr_en, read_transaction_completed,
                     read_resp_error, busy}), 64'd0);
  endtask

  // One request end to end; negative beat indices disable that feature.
  task automatic do_burst(input logic [7:0] addr, input logic [8:0] beats,
                          input logic [2:0] size, input logic [1:0] btype,
                          input int ar_delay, input int err_beat, input int last_beat,
                          input int full_beat, input int full_cyc,
                          input int abort_after, input int poke_beat);
    logic illegal;
    logic exp_err;
    logic got;
    int   n_push;
    illegal = (beats == 9'd0) || (beats > 9'd256) || ((beats > 9'd16) && (btype != 2'd1));
    exp_err = illegal || (err_beat >= 0 && err_beat < int'(beats)) ||
              (last_beat != int'(beats) - 1);
    if (!illegal) ar_q.push_back({addr, 8'(beats - 9'd1), size, btype});
    n_push = illegal ? 0 : ((abort_after >= 0) ? abort_after : int'(beats));
    for (int k = 0; k < n_push; k++) data_q.push_back(beat_data(addr, k));
    if (abort_after < 0) cmp_q.push_back(exp_err);

    src_addr = addr; read_beats = beats; read_burst_size = size; read_burst_type = btype;
    start_read = 1'b1;
    @(posedge clk); #1;
    start_read = 1'b0;

    if (illegal) begin
      @(negedge clk);
      check("illegal_no_arvalid", 64'(M_AXI_ARVALID), 64'd0);
      check("illegal_completion", 64'(read_transaction_completed), 64'd1);
      check("illegal_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("illegal_pulse_end", 64'({read_transaction_completed, busy, M_AXI_ARVALID}), 64'd0);
      check("illegal_err_held", 64'(read_resp_error), 64'd1);
      @(posedge clk); #1;
      return;
    end

    @(negedge clk);
    check("arvalid_next_cycle", 64'(M_AXI_ARVALID), 64'd1);
    check("err_cleared_on_start", 64'(read_resp_error), 64'd0);
    check("busy_in_addr", 64'(busy), 64'd1);
    for (int i = 0; i < ar_delay; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("ar_held", 64'({M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARBURST}),
            64'({1'b1, addr, 8'(beats - 9'd1), btype}));
    end
    @(posedge clk); #1;
    M_AXI_ARREADY = 1'b1;
    @(negedge clk);
    check("ar_handshake", 64'(M_AXI_ARVALID), 64'd1);
    @(posedge clk); #1;
    M_AXI_ARREADY = 1'b0;

    for (int k = 0; k < int'(beats); k++) begin
      if (k == abort_after) begin
        M_AXI_RVALID = 1'b0;
        AXI_areset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("midburst_reset_outputs");
        AXI_areset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("after_reset_idle", 64'({busy, read_transaction_completed}), 64'd0);
        @(posedge clk); #1;
        return;
      end
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = beat_data(addr, k);
      M_AXI_RRESP  = (k == err_beat) ? 2'b10 : 2'b00;
      M_AXI_RLAST  = (k == last_beat);
      if (k == poke_beat) start_read = 1'b1;
      if (k == full_beat) begin
        fifo_full = 1'b1;
        for (int c = 0; c < full_cyc; c++) begin
          @(negedge clk);
          check("rready_low_when_full", 64'({M_AXI_RREADY, fifo_wr_en}), 64'd0);
          @(posedge clk); #1;
        end
        fifo_full = 1'b0;
      end
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        if (M_AXI_RREADY) got = 1'b1;
        @(posedge clk); #1;
      end
      check("beat_handshake", 64'(got), 64'd1);
      start_read = 1'b0;
    end
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; M_AXI_RRESP = 2'b00;
    @(negedge clk);
    check("completion_after_last", 64'({read_transaction_completed, busy}), 64'd3);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_after_done", 64'({read_transaction_completed, busy, M_AXI_ARVALID}), 64'd0);
    check("err_held_after_done", 64'(read_resp_error), 64'(exp_err));
    @(posedge clk); #1;
  endtask

  initial begin
    AXI_areset = 1'b1; src_addr = '0; read_burst_type = '0; read_burst_size = '0;
    read_beats = '0; start_read = 1'b0; M_AXI_ARREADY = 1'b0; M_AXI_RDATA = '0;
    M_AXI_RRESP = '0; M_AXI_RLAST = 1'b0; M_AXI_RVALID = 1'b0; fifo_full = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("reset_outputs");
    @(posedge clk); #1;
    AXI_areset = 1'b0;
    @(posedge clk); #1;

    //        addr   beats  sz    type  ard err last full fc  abort poke
    do_burst(8'h40, 9'd4,  3'd2, 2'd1, 1, -1,  3,  -1, 0,  -1,  -1); // legal INCR
    do_burst(8'h80, 9'd8,  3'd2, 2'd1, 0, -1,  7,   3, 3,  -1,  -1); // backpressure
    do_burst(8'h10, 9'd3,  3'd2, 2'd1, 0,  1,  2,  -1, 0,  -1,   1); // SLVERR + ignored start
    do_burst(8'h20, 9'd2,  3'd2, 2'd1, 0, -1,  1,  -1, 0,  -1,  -1); // flag cleared
    do_burst(8'h00, 9'd0,  3'd2, 2'd1, 0, -1, -1,  -1, 0,  -1,  -1); // illegal: 0
    do_burst(8'h00, 9'd300,3'd2, 2'd1, 0, -1, -1,  -1, 0,  -1,  -1); // illegal: 300
    do_burst(8'h00, 9'd17, 3'd2, 2'd2, 0, -1, -1,  -1, 0,  -1,  -1); // illegal: 17 WRAP
    do_burst(8'h30, 9'd4,  3'd2, 2'd1, 2, -1,  1,  -1, 0,  -1,  -1); // early RLAST
    do_burst(8'h50, 9'd6,  3'd2, 2'd1, 0, -1,  5,  -1, 0,   2,  -1); // mid-burst reset
    do_burst(8'h60, 9'd16, 3'd1, 2'd2, 0, -1, 15,  -1, 0,  -1,  -1); // WRAP 16 boundary
    do_burst(8'hF0, 9'd256,3'd2, 2'd1, 0, -1,255,  -1, 0,  -1,  -1); // INCR 256 boundary

    repeat (3) @(posedge clk);
    #1;
    check("ar_queue_drained", 64'(ar_q.size()), 64'd0);
    check("data_queue_drained", 64'(data_q.size()), 64'd0);
    check("completion_queue_drained", 64'(cmp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
